pwm_fade_controller: RTL and testbench

//   Sequences the PWM duty-cycle datapath: takes the SPI-written target duty and ramps the

---
 rtl/pwm_pkg.sv | 19 +
 rtl/pwm_fade_controller_if.sv | 32 +++
 rtl/fade_tick_gen.sv | 45 ++++
 rtl/pwm_fade_controller.sv | 122 ++++++++++++
 tb/tb_pwm_fade_controller.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : pwm_pkg                                                       |
// | Purpose : Shared constants for the PWM duty-cycle fade datapath:        |
// |           fade FSM state encodings and default datapath widths.         |
// | Ports   : none (package)                                                |
// | Rev     : 1.0 - initial release                                         |
// +------------------------------------------------------------------------+
package pwm_pkg;

  localparam int DUTY_W_DEF = 8;
  localparam int DIV_W_DEF  = 16;

  localparam logic [1:0] FADE_IDLE = 2'd0;
  localparam logic [1:0] FADE_UP   = 2'd1;
  localparam logic [1:0] FADE_DOWN = 2'd2;

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/pwm_fade_controller_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface : pwm_fade_controller_if                                      |
// | Purpose   : Bundles the fade controller's control inputs and status     |
// |             outputs.                                                    |
// | Signals   : target_duty, ramp_en, step, rate_div  (master -> slave)     |
// |             duty_out, busy, done                  (slave -> master)     |
// | Rev       : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
interface pwm_fade_controller_if #(
  parameter int DUTY_W = pwm_pkg::DUTY_W_DEF,
  parameter int DIV_W  = pwm_pkg::DIV_W_DEF
);
  logic [DUTY_W-1:0] target_duty;
  logic              ramp_en;
  logic [DUTY_W-1:0] step;
  logic [DIV_W-1:0]  rate_div;
  logic [DUTY_W-1:0] duty_out;
  logic              busy;
  logic              done;

  modport master (
    output target_duty, ramp_en, step, rate_div,
    input  duty_out, busy, done
  );

  modport slave (
    input  target_duty, ramp_en, step, rate_div,
    output duty_out, busy, done
  );
endinterface : pwm_fade_controller_if
`default_nettype wire

// File: rtl/fade_tick_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : fade_tick_gen                                                 |
// | Purpose : Ramp-rate prescaler. Counts 0..rate_div_i and raises tick_o   |
// |           in the cycle the count equals rate_div_i, then wraps to 0.    |
// | Ports   : clk, rst_n      clock / async active-low reset                 |
// |           clr_i          force the count back to 0 next cycle           |
// |           rate_div_i     tick period minus one                          |
// |           tick_o         combinational tick strobe                      |
// | Rev     : 1.0 - initial release                                         |
// +------------------------------------------------------------------------+
module fade_tick_gen #(
  parameter int DIV_W = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             clr_i,
  input  wire logic [DIV_W-1:0] rate_div_i,
  output logic                  tick_o
);

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;

  // Equality compare only: if rate_div shrinks below the running count the
  // counter simply runs up to all-ones and wraps before matching again.
  assign tick_o = (count_q == rate_div_i);

  always_comb begin
    count_d = count_q + DIV_W'(1);
    if (clr_i || tick_o) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : fade_tick_gen
`default_nettype wire

// File: rtl/pwm_fade_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : pwm_fade_controller                                           |
// | Purpose : Ramps the duty fed to the PWM peripheral toward the SPI       |
// |           target in programmable steps at a programmable rate.          |
// | Ports   : clk            system clock                                   |
// |           rst_n          async-assert / sync-release active-low reset   |
// |           fade_if.slave  target_duty, ramp_en, step, rate_div in;       |
// |                          duty_out, busy, done out                       |
// | Rev     : 1.0 - initial release                                         |
// +------------------------------------------------------------------------+
module pwm_fade_controller
  import pwm_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  pwm_fade_controller_if.slave  fade_if
);

  logic [1:0]        rst_sync_q;
  logic              rst_int_n;
  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [DUTY_W-1:0] duty_q;
  logic [DUTY_W-1:0] duty_d;
  logic              done_q;
  logic              done_d;
  logic [DUTY_W-1:0] step_eff;
  logic [DUTY_W-1:0] gap;
  logic              tick;
  logic              tick_clr;

  // Reset asserts immediately, releases two clock edges after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end
  assign rst_int_n = rst_sync_q[1];

  assign step_eff = (fade_if.step == '0) ? DUTY_W'(1) : fade_if.step;

  // Prescaler restarts whenever the FSM is idle or about to change state, so
  // every ramp segment waits a full rate_div+1 period before its first step.
  assign tick_clr = (state_q == FADE_IDLE) || (state_d != state_q);

  fade_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick_gen (
    .clk        (clk),
    .rst_n      (rst_int_n),
    .clr_i      (tick_clr),
    .rate_div_i (fade_if.rate_div),
    .tick_o     (tick)
  );

  // Direction is re-derived every cycle from target vs. registered duty;
  // a direction change takes priority over a coincident tick. Landing is
  // detected on the remaining gap so the step never overshoots or wraps.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    done_d  = 1'b0;
    gap     = '0;
    if (!fade_if.ramp_en) begin
      duty_d  = fade_if.target_duty;
      state_d = FADE_IDLE;
    end else if (fade_if.target_duty > duty_q) begin
      if (state_q != FADE_UP) begin
        state_d = FADE_UP;
      end else if (tick) begin
        gap = fade_if.target_duty - duty_q;
        if (gap <= step_eff) begin
          duty_d  = fade_if.target_duty;
          state_d = FADE_IDLE;
          done_d  = 1'b1;
        end else begin
          duty_d = duty_q + step_eff;
        end
      end
    end else if (fade_if.target_duty < duty_q) begin
      if (state_q != FADE_DOWN) begin
        state_d = FADE_DOWN;
      end else if (tick) begin
        gap = duty_q - fade_if.target_duty;
        if (gap <= step_eff) begin
          duty_d  = fade_if.target_duty;
          state_d = FADE_IDLE;
          done_d  = 1'b1;
        end else begin
          duty_d = duty_q - step_eff;
        end
      end
    end else begin
      // Target met without a step of ours: settle quietly, no done pulse.
      state_d = FADE_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= FADE_IDLE;
      duty_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      done_q  <= done_d;
    end
  end

  assign fade_if.duty_out = duty_q;
  assign fade_if.busy     = (state_q != FADE_IDLE);
  assign fade_if.done     = done_q;

endmodule : pwm_fade_controller
`default_nettype wire

// File: tb/tb_pwm_fade_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_pwm_fade_controller                                        |
// | Purpose : Self-checking bench for pwm_fade_controller: directed         |
// |           scenarios plus randomized traffic against a reference model.  |
// | Ports   : none                                                          |
// | Rev     : 1.0 - initial release                                         |
// +------------------------------------------------------------------------+
module tb_pwm_fade_controller;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pwm_fade_controller_if #(.DUTY_W(8), .DIV_W(16)) fif ();

  pwm_fade_controller #(.DUTY_W(8), .DIV_W(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .fade_if (fif.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 = settled, 1 = rising, 2 = falling.
  int m_duty = 0;
  int m_mode = 0;
  int m_cnt  = 0;
  int m_rel  = 0;
  bit m_done = 1'b0;

  task automatic drive(input bit en, input int tgt, input int stp, input int rd);
    fif.ramp_en     = en;
    fif.target_duty = 8'(tgt);
    fif.step        = 8'(stp);
    fif.rate_div    = 16'(rd);
  endtask

  // Advance one clock, evolving the model from the inputs held before the edge.
  task automatic step_clk();
    int nduty, nmode, ncnt, se, want, tgt;
    bit ndone, pre_rst;
    nduty = m_duty; nmode = m_mode; ncnt = m_cnt; ndone = 1'b0;
    pre_rst = rst_n;
    tgt = int'(fif.target_duty);
    if (!rst_n || m_rel < 2) begin
      nduty = 0; nmode = 0; ncnt = 0;
    end else if (!fif.ramp_en) begin
      nduty = tgt; nmode = 0; ncnt = 0;
    end else begin
      se   = (fif.step == 8'd0) ? 1 : int'(fif.step);
      want = (tgt > m_duty) ? 1 : ((tgt < m_duty) ? 2 : 0);
      if (want != m_mode) begin
        nmode = want; ncnt = 0;
      end else if (m_mode == 0) begin
        ncnt = 0;
      end else if (m_cnt == int'(fif.rate_div)) begin
        ncnt = 0;
        if (m_mode == 1) nduty = (m_duty + se < tgt) ? m_duty + se : tgt;
        else             nduty = (m_duty - se > tgt) ? m_duty - se : tgt;
        if (nduty == tgt) begin
          nmode = 0; ndone = 1'b1;
        end
      end else begin
        ncnt = (m_cnt + 1) % 65536;
      end
    end
    @(posedge clk);
    #1;
    m_duty = nduty; m_mode = nmode; m_cnt = ncnt; m_done = ndone;
    m_rel = pre_rst ? ((m_rel < 2) ? m_rel + 1 : 2) : 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    #2;
    checks++;
    if ({fif.duty_out, fif.busy, fif.done} !== 10'd0) begin
      errors++;
      $display("FAIL reset_state: got duty=%h busy=%b done=%b, want 00/0/0",
               fif.duty_out, fif.busy, fif.done);
    end
    step_clk(); step_clk();
    rst_n = 1'b1;
    repeat (4) step_clk();
    checks++;
    if (fif.duty_out !== 8'h00 || fif.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got duty=%h busy=%b, want 00/0", fif.duty_out, fif.busy);
    end
  endtask

  task automatic test_bypass();
    bit saw_busy = 1'b0;
    drive(0, 8'h00, 0, 0);
    step_clk();
    drive(0, 8'hA5, 0, 0);
    step_clk();
    checks++;
    if (fif.duty_out !== 8'hA5) begin
      errors++;
      $display("FAIL bypass_duty: got %h want a5", fif.duty_out);
    end
    if (fif.busy) saw_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step_clk();
      if (fif.busy) saw_busy = 1'b1;
    end
    checks++;
    if (saw_busy !== 1'b0) begin
      errors++;
      $display("FAIL bypass_busy: got busy seen=%b want 0", saw_busy);
    end
  endtask

  task automatic test_up_ramp();
    int idx[$];
    int val[$];
    int dones = 0;
    int done_at = -1;
    int prev;
    drive(0, 0, 0, 0);
    step_clk();
    drive(1, 8'h38, 8'h10, 3);
    prev = 0;
    for (int n = 1; n <= 25; n++) begin
      step_clk();
      checks++;
      if ({fif.duty_out, fif.busy, fif.done} !== {8'(m_duty), m_mode != 0, m_done}) begin
        errors++;
        $display("FAIL up_model c%0d: got %h/%b/%b want %h/%b/%b", n, fif.duty_out,
                 fif.busy, fif.done, 8'(m_duty), m_mode != 0, m_done);
      end
      if (int'(fif.duty_out) != prev) begin
        idx.push_back(n); val.push_back(int'(fif.duty_out)); prev = int'(fif.duty_out);
      end
      if (fif.done === 1'b1) begin
        dones++; done_at = n;
      end
    end
    checks++;
    if (idx.size() != 4 || idx[0] != 5 || val[0] != 'h10 || idx[1] != 9 || val[1] != 'h20 ||
        idx[2] != 13 || val[2] != 'h30 || idx[3] != 17 || val[3] != 'h38) begin
      errors++;
      $display("FAIL up_sequence: got %0d updates (first at c%0d), want 10@5 20@9 30@13 38@17",
               idx.size(), (idx.size() > 0) ? idx[0] : -1);
    end
    checks++;
    if (dones != 1 || done_at != 17 || fif.busy !== 1'b0) begin
      errors++;
      $display("FAIL up_done: got %0d pulses at c%0d busy=%b, want 1 at c17 busy 0",
               dones, done_at, fif.busy);
    end
  endtask

  task automatic test_saturation();
    drive(0, 8'hF8, 0, 0); step_clk();
    drive(1, 8'hFF, 8'h10, 0); step_clk();
    step_clk();
    checks++;
    if (fif.duty_out !== 8'hFF || fif.done !== 1'b1) begin
      errors++;
      $display("FAIL sat_up: got duty=%h done=%b want ff/1", fif.duty_out, fif.done);
    end
    drive(0, 8'h05, 0, 0); step_clk();
    drive(1, 8'h00, 8'h10, 0); step_clk();
    step_clk();
    checks++;
    if (fif.duty_out !== 8'h00 || fif.done !== 1'b1) begin
      errors++;
      $display("FAIL sat_down: got duty=%h done=%b want 00/1", fif.duty_out, fif.done);
    end
  endtask

  task automatic test_reversal();
    int dones = 0;
    drive(0, 8'h30, 0, 0); step_clk();
    drive(1, 8'h80, 8'h10, 3); step_clk();
    repeat (3) step_clk();          // prescaler now sits on its tick count
    drive(1, 8'h10, 8'h10, 3);
    step_clk();
    checks++;
    if (fif.duty_out !== 8'h30 || fif.busy !== 1'b1) begin
      errors++;
      $display("FAIL rev_nostep: got duty=%h busy=%b want 30/1", fif.duty_out, fif.busy);
    end
    for (int n = 0; n < 20; n++) begin
      step_clk();
      if (fif.done === 1'b1) dones++;
    end
    checks++;
    if (fif.duty_out !== 8'h10 || dones != 1 || fif.busy !== 1'b0) begin
      errors++;
      $display("FAIL rev_land: got duty=%h dones=%0d busy=%b want 10/1/0",
               fif.duty_out, dones, fif.busy);
    end
  endtask

  task automatic test_step0();
    drive(0, 0, 0, 0); step_clk();
    drive(1, 3, 0, 0); step_clk();
    checks++;
    if (fif.duty_out !== 8'd0 || fif.busy !== 1'b1) begin
      errors++;
      $display("FAIL step0_entry: got duty=%h busy=%b want 00/1", fif.duty_out, fif.busy);
    end
    for (int k = 1; k <= 3; k++) begin
      step_clk();
      checks++;
      if (int'(fif.duty_out) != k || fif.done !== (k == 3)) begin
        errors++;
        $display("FAIL step0_seq%0d: got duty=%h done=%b want %h/%b", k, fif.duty_out,
                 fif.done, 8'(k), k == 3);
      end
    end
  endtask

  task automatic test_reset_mid_ramp();
    drive(0, 0, 0, 0); step_clk();
    drive(1, 8'h80, 8'h10, 0);
    repeat (5) step_clk();
    checks++;
    if (fif.duty_out !== 8'h40 || fif.busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: got duty=%h busy=%b want 40/1", fif.duty_out, fif.busy);
    end
    #3 rst_n = 1'b0;
    #1;
    m_duty = 0; m_mode = 0; m_cnt = 0; m_done = 1'b0; m_rel = 0;
    checks++;
    if ({fif.duty_out, fif.busy, fif.done} !== 10'd0) begin
      errors++;
      $display("FAIL rstmid_async: got duty=%h busy=%b done=%b want 00/0/0",
               fif.duty_out, fif.busy, fif.done);
    end
    step_clk(); step_clk();
    rst_n = 1'b1;
    drive(0, 0, 0, 0);
    repeat (3) step_clk();
  endtask

  task automatic test_random();
    int len;
    for (int t = 0; t < 40; t++) begin
      drive(($urandom_range(0, 4) != 0), $urandom_range(0, 255), $urandom_range(0, 40),
            $urandom_range(0, 3));
      len = $urandom_range(1, 30);
      for (int c = 0; c < len; c++) begin
        step_clk();
        checks++;
        if ({fif.duty_out, fif.busy, fif.done} !== {8'(m_duty), m_mode != 0, m_done}) begin
          errors++;
          $display("FAIL random t%0d c%0d: got %h/%b/%b want %h/%b/%b", t, c, fif.duty_out,
                   fif.busy, fif.done, 8'(m_duty), m_mode != 0, m_done);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_up_ramp();
    test_saturation();
    test_reversal();
    test_step0();
    test_reset_mid_ramp();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pwm_fade_controller
`default_nettype wire
